// File: rtl/kgp_isa_pkg.sv
// KGP-RISC ISA constants shared by the sequencer and its helpers:
// opcode ranges, function codes, sequencer state encoding and error codes.
package kgp_isa_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ALUI_LO = 6'b000001;
  localparam logic [5:0] OP_ALUI_HI = 6'b000101;
  localparam logic [5:0] OP_CBR_LO  = 6'b000110;
  localparam logic [5:0] OP_CBR_HI  = 6'b001000;
  localparam logic [5:0] OP_LD      = 6'b100000;
  localparam logic [5:0] OP_ST      = 6'b100001;
  localparam logic [5:0] OP_UBR_LO  = 6'b100101;
  localparam logic [5:0] OP_UBR_HI  = 6'b101000;
  localparam logic [5:0] OP_CALL    = 6'b100110;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [7:0] FN_NOP = 8'b00000000;
  localparam logic [7:0] FN_BR  = 8'b00100000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HALT    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seqState_t;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_NOP,
    CL_RBR,
    CL_CBR,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_CALL,
    CL_HALT,
    CL_ILLEGAL
  } instrClass_t;

  // Call sits inside the unconditional-branch range, so it is tested first.
  function automatic instrClass_t classify(input logic [5:0] op, input logic [7:0] fn);
    instrClass_t cls;
    cls = CL_ILLEGAL;
    if (op == OP_RTYPE) begin
      if (fn == FN_NOP)     cls = CL_NOP;
      else if (fn == FN_BR) cls = CL_RBR;
      else                  cls = CL_ALU;
    end else if (op >= OP_ALUI_LO && op <= OP_ALUI_HI) begin
      cls = CL_ALU;
    end else if (op >= OP_CBR_LO && op <= OP_CBR_HI) begin
      cls = CL_CBR;
    end else if (op == OP_LD) begin
      cls = CL_LD;
    end else if (op == OP_ST) begin
      cls = CL_ST;
    end else if (op == OP_CALL) begin
      cls = CL_CALL;
    end else if (op >= OP_UBR_LO && op <= OP_UBR_HI) begin
      cls = CL_JMP;
    end else if (op == OP_HALT) begin
      cls = CL_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/kgp_req_timeout.sv
// Wait-cycle counter for a memory request; expired flags the last
// unacknowledged cycle before the limit is reached.
module kgp_req_timeout
  import kgp_isa_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/kgp_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC core.
// Every output is registered from the next-state decision or is the state itself.
module kgp_multicycle_sequencer
  import kgp_isa_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      instr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             alu_en,
  output logic             reg_we,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  seqState_t   state;
  seqState_t   nextState;
  instrClass_t cls;
  logic [5:0]  opReg;
  logic [7:0]  fnReg;
  logic [1:0]  nextErr;
  logic        ackIn;
  logic        tmoEn;
  logic        tmoExpired;
  logic        retire;
  logic        unusedInstrBits;

  assign unusedInstrBits = ^instr[25:8];

  kgp_req_timeout #(.LIMIT(MEM_TIMEOUT)) uTimeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!tmoEn),
    .en      (tmoEn),
    .expired (tmoExpired)
  );

  always_comb begin
    cls       = classify(opReg, fnReg);
    ackIn     = 1'b0;
    if (state == FETCH)    ackIn = imem_ack;
    else if (state == MEM) ackIn = dmem_ack;
    // Counting only while a request is waiting also clears it on entry to FETCH/MEM.
    tmoEn     = ((state == FETCH) || (state == MEM)) && !ackIn;
    nextState = state;
    nextErr   = err_code;
    unique case (state)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          nextState = DECODE;
        end else if (tmoExpired) begin
          nextState = HALT;
          nextErr   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        if (cls == CL_HALT) begin
          nextState = HALT;
          nextErr   = ERR_HALT;
        end else if (cls == CL_ILLEGAL) begin
          nextState = HALT;
          nextErr   = ERR_ILLEGAL;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        if (cls == CL_LD || cls == CL_ST)        nextState = MEM;
        else if (cls == CL_ALU || cls == CL_CALL) nextState = WB;
        else                                      nextState = FETCH;
      end
      MEM: begin
        if (dmem_ack) begin
          nextState = (cls == CL_ST) ? FETCH : WB;
        end else if (tmoExpired) begin
          nextState = HALT;
          nextErr   = ERR_TIMEOUT;
        end
      end
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
    retire = (nextState == FETCH) &&
             ((state == EXEC) || (state == MEM) || (state == WB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opReg    <= '0;
      fnReg    <= '0;
      err_code <= ERR_NONE;
      retired  <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      ir_we    <= 1'b0;
      alu_en   <= 1'b0;
      reg_we   <= 1'b0;
      pc_we    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= nextState;
      err_code <= nextErr;
      if (state == FETCH && imem_ack) begin
        opReg <= instr[31:26];
        fnReg <= instr[7:0];
      end
      if (retire) retired <= retired + CNT_W'(1);
      ir_we    <= (state == FETCH) && imem_ack;
      pc_we    <= retire;
      imem_req <= (nextState == FETCH);
      dmem_req <= (nextState == MEM);
      dmem_we  <= (nextState == MEM) && (cls == CL_ST);
      alu_en   <= (nextState == EXEC);
      reg_we   <= (nextState == WB);
      busy     <= (nextState != IDLE) && (nextState != HALT);
      halted   <= (nextState == HALT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_kgp_multicycle_sequencer.sv
// Directed bench for kgp_multicycle_sequencer: each task runs one scenario
// and compares observed outputs against hand-computed values.
module tb_kgp_multicycle_sequencer;

  localparam logic [31:0] W_ALUI  = {6'b000001, 26'h0};
  localparam logic [31:0] W_LD    = {6'b100000, 26'h0};
  localparam logic [31:0] W_ST    = {6'b100001, 26'h0};
  localparam logic [31:0] W_CBR   = {6'b000111, 26'h0};
  localparam logic [31:0] W_NOP   = {6'b000000, 18'h0, 8'h00};
  localparam logic [31:0] W_HALT  = {6'b111111, 26'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we;
  logic        busy, halted;
  logic [1:0]  err_code;
  logic [15:0] retired;
  logic [2:0]  state_o;

  int vectors = 0;
  int miscompares = 0;
  int nIr, nAlu, nReg, nPc, nDmem, nDwe;

  kgp_multicycle_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .alu_en(alu_en), .reg_we(reg_we), .pc_we(pc_we),
    .busy(busy), .halted(halted), .err_code(err_code),
    .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    nIr   += int'(ir_we);
    nAlu  += int'(alu_en);
    nReg  += int'(reg_we);
    nPc   += int'(pc_we);
    nDmem += int'(dmem_req);
    nDwe  += int'(dmem_we);
  endtask

  task automatic clearCounts();
    nIr = 0; nAlu = 0; nReg = 0; nPc = 0; nDmem = 0; nDwe = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic startRun();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Responds to requests with the given ack delays until retire or halt.
  task automatic runInstr(input logic [31:0] word, input int iDelay, input int dDelay,
                          output int cyc, output int dAckCyc, output bit done);
    int iw, dw;
    iw = 0; dw = 0; cyc = 0; dAckCyc = -1; done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0;
      if (state_o == 3'd1) begin
        if (iw == iDelay) begin imem_ack = 1'b1; instr = word; end
        iw++;
      end
      if (state_o == 3'd4) begin
        if (dw == dDelay) begin dmem_ack = 1'b1; dAckCyc = cyc; end
        dw++;
      end
      cycle();
      cyc++;
      if (pc_we || halted) done = 1'b1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++; if ({imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we} !== 7'b0) begin miscompares++; $display("FAIL reset_strobes: got %b expected 0000000", {imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we}); end
    doReset();
    vectors++; if (state_o !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    vectors++; if ({busy, halted, err_code} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {busy, halted, err_code}); end
    vectors++; if (retired !== 16'd0) begin miscompares++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    clearCounts();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    cycle(); cycle();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    cycle();
    vectors++; if (state_o !== 3'd0 || nIr !== 0) begin miscompares++; $display("FAIL idle_ack_ignored: got state %0d ir %0d expected state 0 ir 0", state_o, nIr); end
  endtask

  task automatic test_alu_imm();
    int cyc, dAck; bit done;
    clearCounts();
    startRun();
    vectors++; if (state_o !== 3'd1 || imem_req !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL start_fetch: got state %0d req %b busy %b expected 1 1 1", state_o, imem_req, busy); end
    runInstr(W_ALUI, 2, 0, cyc, dAck, done);
    vectors++; if (!done || cyc !== 6) begin miscompares++; $display("FAIL alui_latency: got %0d cycles done %b expected 6", cyc, done); end
    vectors++; if ({nIr, nAlu, nReg, nPc} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin miscompares++; $display("FAIL alui_pulses: got ir %0d alu %0d reg %0d pc %0d expected 1 each", nIr, nAlu, nReg, nPc); end
    vectors++; if (retired !== 16'd1 || state_o !== 3'd1) begin miscompares++; $display("FAIL alui_retire: got retired %0d state %0d expected 1 1", retired, state_o); end
  endtask

  task automatic test_load();
    int cyc, dAck; bit done;
    clearCounts();
    runInstr(W_LD, 0, 3, cyc, dAck, done);
    vectors++; if (!done || cyc !== 8) begin miscompares++; $display("FAIL load_latency: got %0d cycles expected 8", cyc); end
    vectors++; if (nDmem !== 4 || nDwe !== 0) begin miscompares++; $display("FAIL load_dmem: got req %0d we %0d expected 4 0", nDmem, nDwe); end
    vectors++; if (nReg !== 1 || nPc !== 1 || retired !== 16'd2) begin miscompares++; $display("FAIL load_wb: got reg %0d pc %0d retired %0d expected 1 1 2", nReg, nPc, retired); end
  endtask

  task automatic test_store();
    int cyc, dAck; bit done;
    clearCounts();
    runInstr(W_ST, 0, 1, cyc, dAck, done);
    vectors++; if (nDmem !== 2 || nDwe !== 2) begin miscompares++; $display("FAIL store_dmem: got req %0d we %0d expected 2 2", nDmem, nDwe); end
    vectors++; if (nReg !== 0 || nPc !== 1) begin miscompares++; $display("FAIL store_pulses: got reg %0d pc %0d expected 0 1", nReg, nPc); end
    vectors++; if (!done || cyc !== dAck + 1 || cyc !== 5) begin miscompares++; $display("FAIL store_pc_timing: got pc at %0d ack at %0d expected 5 and 4", cyc, dAck); end
    vectors++; if (retired !== 16'd3) begin miscompares++; $display("FAIL store_retired: got %0d expected 3", retired); end
  endtask

  task automatic test_branch_nop();
    int cyc, dAck; bit done;
    doReset();
    startRun();
    clearCounts();
    runInstr(W_CBR, 0, 0, cyc, dAck, done);
    vectors++; if (!done || cyc !== 3 || nReg !== 0 || nPc !== 1) begin miscompares++; $display("FAIL cbr: got cyc %0d reg %0d pc %0d expected 3 0 1", cyc, nReg, nPc); end
    runInstr(W_NOP, 1, 0, cyc, dAck, done);
    vectors++; if (!done || cyc !== 4 || nReg !== 0 || nPc !== 2) begin miscompares++; $display("FAIL nop: got cyc %0d reg %0d pc %0d expected 4 0 2", cyc, nReg, nPc); end
    vectors++; if (retired !== 16'd2 || nAlu !== 2) begin miscompares++; $display("FAIL branch_nop_retired: got retired %0d alu %0d expected 2 2", retired, nAlu); end
  endtask

  task automatic test_classes();
    logic [31:0] tblWord [9] = '{
      {6'b000000, 18'h0, 8'h01}, {6'b000000, 18'h0, 8'h20}, {6'b000110, 26'h0},
      {6'b001000, 26'h0}, {6'b000101, 26'h0}, {6'b100101, 26'h0},
      {6'b100110, 26'h0}, {6'b101000, 26'h0}, {6'b100111, 26'h0}};
    int tblReg [9] = '{1, 0, 0, 0, 1, 0, 1, 0, 0};
    int cyc, dAck; bit done;
    for (int i = 0; i < 9; i++) begin
      clearCounts();
      runInstr(tblWord[i], 0, 0, cyc, dAck, done);
      vectors++; if (!done || nReg !== tblReg[i] || cyc !== 3 + tblReg[i]) begin miscompares++; $display("FAIL class_%0d: got reg %0d cyc %0d expected reg %0d cyc %0d", i, nReg, cyc, tblReg[i], 3 + tblReg[i]); end
    end
    vectors++; if (retired !== 16'd11) begin miscompares++; $display("FAIL class_retired: got %0d expected 11", retired); end
  endtask

  task automatic test_halt_instr();
    int cyc, dAck; bit done;
    doReset();
    startRun();
    runInstr(W_ALUI, 0, 0, cyc, dAck, done);
    runInstr(W_HALT, 0, 0, cyc, dAck, done);
    vectors++; if (!done || cyc !== 2 || state_o !== 3'd6) begin miscompares++; $display("FAIL halt_entry: got cyc %0d state %0d expected 2 6", cyc, state_o); end
    vectors++; if (err_code !== 2'b01 || retired !== 16'd1) begin miscompares++; $display("FAIL halt_err: got err %b retired %0d expected 01 1", err_code, retired); end
    vectors++; if ({halted, busy, imem_req} !== 3'b100) begin miscompares++; $display("FAIL halt_flags: got %b expected 100", {halted, busy, imem_req}); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [4] = '{6'b010101, 6'b001001, 6'b100100, 6'b101001};
    int cyc, dAck; bit done;
    for (int i = 0; i < 4; i++) begin
      doReset();
      startRun();
      runInstr({ops[i], 26'h0}, 0, 0, cyc, dAck, done);
      vectors++; if (!done || err_code !== 2'b10 || halted !== 1'b1 || retired !== 16'd0) begin miscompares++; $display("FAIL illegal_%0d: got err %b halted %b retired %0d expected 10 1 0", i, err_code, halted, retired); end
    end
    startRun();
    cycle();
    vectors++; if (state_o !== 3'd6 || imem_req !== 1'b0 || err_code !== 2'b10) begin miscompares++; $display("FAIL halt_start_ignored: got state %0d req %b err %b expected 6 0 10", state_o, imem_req, err_code); end
    rst_n = 1'b0;
    #2;
    vectors++; if (state_o !== 3'd0 || halted !== 1'b0 || err_code !== 2'b00) begin miscompares++; $display("FAIL async_clear: got state %0d halted %b err %b expected 0 0 00", state_o, halted, err_code); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_timeout();
    int n, cyc, dAck; bit done;
    doReset();
    startRun();
    n = 0;
    for (int k = 0; k < 40 && imem_req; k++) begin
      n++;
      cycle();
    end
    vectors++; if (n !== 15) begin miscompares++; $display("FAIL imem_timeout_len: got %0d cycles expected 15", n); end
    vectors++; if (err_code !== 2'b11 || halted !== 1'b1 || retired !== 16'd0) begin miscompares++; $display("FAIL imem_timeout_err: got err %b halted %b retired %0d expected 11 1 0", err_code, halted, retired); end
    doReset();
    startRun();
    runInstr(W_ALUI, 14, 0, cyc, dAck, done);
    vectors++; if (!done || cyc !== 18 || retired !== 16'd1 || err_code !== 2'b00) begin miscompares++; $display("FAIL ack_on_limit: got cyc %0d retired %0d err %b expected 18 1 00", cyc, retired, err_code); end
    clearCounts();
    runInstr(W_LD, 0, 99, cyc, dAck, done);
    vectors++; if (!done || nDmem !== 15 || err_code !== 2'b11 || dmem_req !== 1'b0) begin miscompares++; $display("FAIL dmem_timeout: got req %0d err %b final req %b expected 15 11 0", nDmem, err_code, dmem_req); end
    vectors++; if (retired !== 16'd1 || nReg !== 0) begin miscompares++; $display("FAIL dmem_timeout_retired: got retired %0d reg %0d expected 1 0", retired, nReg); end
  endtask

  task automatic test_reset_mid();
    doReset();
    startRun();
    imem_ack = 1'b1; instr = W_LD;
    cycle();
    imem_ack = 1'b0; instr = '0;
    cycle(); cycle();
    vectors++; if (dmem_req !== 1'b1 || state_o !== 3'd4) begin miscompares++; $display("FAIL mid_in_mem: got req %b state %0d expected 1 4", dmem_req, state_o); end
    rst_n = 1'b0;
    #2;
    vectors++; if (dmem_req !== 1'b0 || busy !== 1'b0 || state_o !== 3'd0) begin miscompares++; $display("FAIL mid_reset_drop: got req %b busy %b state %0d expected 0 0 0", dmem_req, busy, state_o); end
    dmem_ack = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    dmem_ack = 1'b0;
    vectors++; if (retired !== 16'd0 || reg_we !== 1'b0 || state_o !== 3'd0) begin miscompares++; $display("FAIL mid_reset_nocomplete: got retired %0d reg %b state %0d expected 0 0 0", retired, reg_we, state_o); end
  endtask

  initial begin
    clearCounts();
    test_reset();
    test_alu_imm();
    test_load();
    test_store();
    test_branch_nop();
    test_classes();
    test_halt_instr();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
